// File: rtl/core_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_pkg: shared core widths and the fetch-pair record.   Rev 1.0
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN             = 32;
  localparam int FETCH_WIDTH      = 2;
  localparam int IMEM_LATENCY     = 1;
  localparam int FETCH_PAIR_BYTES = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr0;
    logic [XLEN-1:0] instr1;
  } fetch_pair_t;

endpackage
`default_nettype wire

// File: rtl/imem_fetch_ctrl_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pair_fifo: synchronous FIFO of fetch pairs; flush beats push/pop.   Rev 1.0
// ---------------------------------------------------------------------------
module fetch_pair_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_pair_t              push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_pair_t              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_pair_t     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_fetch_ctrl: paired imem request sequencer with epoch-tagged response
// filtering and a credit-managed fetch-pair queue.   Rev 1.0
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter int               XLEN      = core_pkg::XLEN,
  parameter int               FETCH_W   = core_pkg::FETCH_WIDTH,
  parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
  parameter int               BUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fetch_en,
  input  logic                          stall,
  input  logic                          redirect_en,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          imem_ren,
  output logic [XLEN-1:0]               imem_addr0,
  output logic [XLEN-1:0]               imem_addr1,
  input  logic                          imem_valid,
  input  logic [XLEN-1:0]               imem_rdata0,
  input  logic [XLEN-1:0]               imem_rdata1,
  output logic [FETCH_W-1:0]            if_valid,
  output logic [FETCH_W-1:0][XLEN-1:0]  if_pc,
  output logic [FETCH_W-1:0][XLEN-1:0]  if_instr,
  output logic [$clog2(BUF_DEPTH):0]    occupancy,
  output logic                          proto_err
);

  import core_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] infl_pc;
  logic            epoch;
  logic            infl_epoch;
  logic            inflight;

  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  fetch_pair_t     head;
  fetch_pair_t     push_data;

  logic [CW:0]     used;
  logic            credit_ok;
  logic            issue;
  logic            push;
  logic            pop;

  // The in-flight request reserves a slot so its response can never overrun.
  assign used      = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign credit_ok = (used < (CW+1)'(BUF_DEPTH));
  assign issue     = fetch_en & ~redirect_en & credit_ok;

  assign imem_ren   = issue;
  assign imem_addr0 = pc;
  assign imem_addr1 = pc + XLEN'(4);

  assign push = imem_valid & inflight & (infl_epoch == epoch) & ~redirect_en & ~full;
  assign pop  = ~empty & ~stall & ~redirect_en;

  assign push_data = '{pc: infl_pc, instr0: imem_rdata0, instr1: imem_rdata1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      epoch      <= 1'b0;
      inflight   <= 1'b0;
      infl_pc    <= '0;
      infl_epoch <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        infl_pc    <= pc;
        infl_epoch <= epoch;
      end
      if (redirect_en) begin
        pc    <= {redirect_pc[XLEN-1:2], 2'b00};
        epoch <= ~epoch;
      end else if (issue) begin
        pc <= pc + XLEN'(FETCH_PAIR_BYTES);
      end
      if (imem_valid && !inflight) proto_err <= 1'b1;
    end
  end

  fetch_pair_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_en),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign occupancy   = count;
  assign if_valid    = {FETCH_W{~empty}};
  assign if_pc[0]    = empty ? '0 : head.pc;
  assign if_pc[1]    = empty ? '0 : head.pc + XLEN'(4);
  assign if_instr[0] = empty ? '0 : head.instr0;
  assign if_instr[1] = empty ? '0 : head.instr1;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl: directed scenarios plus random traffic against a queue model.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             fetch_en;
  logic             stall;
  logic             redirect_en;
  logic [31:0]      redirect_pc;
  logic             imem_ren;
  logic [31:0]      imem_addr0;
  logic [31:0]      imem_addr1;
  logic             imem_valid;
  logic [31:0]      imem_rdata0;
  logic [31:0]      imem_rdata1;
  logic [1:0]       if_valid;
  logic [1:0][31:0] if_pc;
  logic [1:0][31:0] if_instr;
  logic [2:0]       occupancy;
  logic             proto_err;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_ren    (imem_ren),
    .imem_addr0  (imem_addr0),
    .imem_addr1  (imem_addr1),
    .imem_valid  (imem_valid),
    .imem_rdata0 (imem_rdata0),
    .imem_rdata1 (imem_rdata1),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .occupancy   (occupancy),
    .proto_err   (proto_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1111_1111 * ((a >> 2) + 32'd1);
  endfunction

  // Reference model: queued pair PCs, next fetch PC, one pending request.
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_pend_pc;
  bit          m_pend;
  bit          m_perr;

  // Memory emulator state: request seen in the previous cycle.
  bit          req_prev;
  logic [31:0] req_a0;
  logic [31:0] req_a1;

  task automatic check_outputs();
    if (m_q.size() == 0) begin
      check_eq("if_valid_empty", 64'(if_valid), 64'd0);
    end else begin
      check_eq("if_valid", 64'(if_valid), 64'd3);
      check_eq("if_pc", if_pc, {m_q[0] + 32'd4, m_q[0]});
      check_eq("if_instr", if_instr, {word(m_q[0] + 32'd4), word(m_q[0])});
    end
    check_eq("occupancy", 64'(occupancy), 64'(m_q.size()));
    check_eq("proto_err", 64'(proto_err), 64'(m_perr));
  endtask

  task automatic step(input bit fe, input bit st, input bit rd, input logic [31:0] rpc, input bit inj);
    bit exp_ren;
    bit push;
    bit pop;
    @(negedge clk);
    check_outputs();
    fetch_en    = fe;
    stall       = st;
    redirect_en = rd;
    redirect_pc = rpc;
    if (req_prev) begin
      imem_valid  = 1'b1;
      imem_rdata0 = word(req_a0);
      imem_rdata1 = word(req_a1);
    end else if (inj) begin
      imem_valid  = 1'b1;
      imem_rdata0 = $urandom;
      imem_rdata1 = $urandom;
    end else begin
      imem_valid  = 1'b0;
      imem_rdata0 = '0;
      imem_rdata1 = '0;
    end
    #1;
    exp_ren = fe && !rd && ((m_q.size() + int'(m_pend)) < DEPTH);
    check_eq("imem_ren", 64'(imem_ren), 64'(exp_ren));
    if (exp_ren && imem_ren) begin
      check_eq("imem_addr0", 64'(imem_addr0), 64'(m_pc));
      check_eq("imem_addr1", 64'(imem_addr1), 64'(m_pc + 32'd4));
    end
    push = imem_valid && m_pend && !rd;
    pop  = (m_q.size() != 0) && !st && !rd;
    if (imem_valid && !m_pend) m_perr = 1'b1;
    if (rd) begin
      m_q.delete();
      m_pc = rpc & ~32'd3;
    end else begin
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(m_pend_pc);
    end
    m_pend    = exp_ren;
    m_pend_pc = m_pc;
    if (exp_ren) m_pc = m_pc + 32'd8;
    req_prev = imem_ren;
    req_a0   = imem_addr0;
    req_a1   = imem_addr1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    fetch_en    = 1'b0;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    imem_valid  = 1'b0;
    imem_rdata0 = '0;
    imem_rdata1 = '0;
    #1;
    check_eq("rst_if_valid", 64'(if_valid), 64'd0);
    check_eq("rst_imem_ren", 64'(imem_ren), 64'd0);
    check_eq("rst_occupancy", 64'(occupancy), 64'd0);
    check_eq("rst_proto_err", 64'(proto_err), 64'd0);
    m_q.delete();
    m_pc      = RST_PC;
    m_pend    = 1'b0;
    m_pend_pc = '0;
    m_perr    = 1'b0;
    req_prev  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    do_reset();

    // Streaming from reset, one pair per cycle.
    for (int i = 0; i < 8; i++) step(1, 0, 0, 32'h0, 0);

    // Decode stall fills the queue, then drains in order.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 32'h0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h0, 0);

    // Redirect with unaligned target.
    step(1, 0, 1, 32'h0000_000A, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h0, 0);

    // PC wrap at the top of the address space.
    step(1, 0, 1, 32'hFFFF_FFF8, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h0, 0);

    // Fill to occupancy 3 with a request in flight, then reset mid-stream.
    for (int i = 0; i < 6; i++) step(1, 1, 0, 32'h0, 0);
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 32'h0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 19) == 0), $urandom, 0);

    // Spurious response with nothing outstanding; error must stick.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, 0);
    for (int i = 0; i < 100; i++)
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 9) == 0));

    @(negedge clk);
    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Request sequencer between the fetch stage and the dual-read instruction memory. Generates paired word requests, tracks the single outstanding access with an epoch tag, and discards responses made stale by a redirect. Buffers returned pairs in a small queue so decode stalls never lose data. The fetch stage consumes the queue head as its if_* bundle.

Parameters:
XLEN, core_pkg::XLEN (32), address/instruction width
FETCH_W, core_pkg::FETCH_WIDTH (2), slots per pair (fixed 2)
RESET_PC, 32'h0000_0000, PC loaded on reset
BUF_DEPTH, 4, queue entries (pairs), power of two, >=2

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
fetch_en  in  1  permit new imem requests
stall  in  1  decode cannot accept; hold outputs
redirect_en  in  1  flush and restart at redirect_pc
redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0)
imem_ren  out  1  memory read request
imem_addr0  out  XLEN  slot-0 word address
imem_addr1  out  XLEN  slot-1 word address
imem_valid  in  1  response valid, exactly 1 cycle after imem_ren
imem_rdata0  in  XLEN  word at imem_addr0
imem_rdata1  in  XLEN  word at imem_addr1
if_valid  out  FETCH_W  slot valid to decode
if_pc  out  FETCH_W x XLEN  slot PCs (packed)
if_instr  out  FETCH_W x XLEN  slot instructions (packed)
occupancy  out  $clog2(BUF_DEPTH)+1  queued pairs (debug)
proto_err  out  1  sticky: imem_valid seen with nothing in flight

Behaviour:
- Reset (async, low): pc=RESET_PC; epoch=0; inflight=0; queue empty; if_valid=0; imem_ren=0; proto_err=0; occupancy=0. Reset asserted mid-operation discards everything, including any in-flight request.
- Credits: credit_ok = (occupancy + inflight) < BUF_DEPTH. A same-cycle pop is not counted, which is conservative.
- Issue (combinational): imem_ren = fetch_en & ~redirect_en & credit_ok.
  - imem_addr0 = pc; imem_addr1 = pc+4.
  - On issue: pc <= pc+8 (mod 2^XLEN, wrap allowed); inflight <= 1; infl_pc <= pc; infl_epoch <= epoch. Without issue, inflight <= 0.
- Response: when imem_valid & inflight & infl_epoch==epoch & ~redirect_en, push {infl_pc, rdata0, rdata1}.
  - PCs come from the controller's own infl_pc, never from memory.
  - Mismatched epoch: drop silently.
  - imem_valid with inflight=0: drop and set proto_err.
- Output: if_valid = {2{~empty}}. if_pc[0]=head.pc, if_pc[1]=head.pc+4, if_instr from head. All registered/queue-driven; no input-to-output combinational path.
- Pop: ~empty & ~stall & ~redirect_en. When stall=1, outputs are held bit-stable.
- Redirect (redirect_en=1, single cycle or held):
  - queue flushed at that edge; epoch toggles; pc <= redirect_pc & ~3; no issue this cycle.
  - Any response arriving in the redirect cycle or the next cycle is dropped.
  - if_valid=0 the cycle after redirect.
  - Redirect has priority over stall, fetch_en, push and pop.
- fetch_en=0: no new issue; the in-flight response is still accepted; the queue keeps draining.
- Latency: issue in cycle N, imem_valid in N+1, pushed at end of N+1, if_valid in N+2. Redirect in cycle R gives first valid output in R+3.
- Throughput: 1 pair/cycle sustained with stall=0.
- Full: occupancy=BUF_DEPTH-1 with inflight=1 blocks issue; a full queue is never overrun.
- Simultaneous push+pop: occupancy unchanged. Push onto an empty queue is not bypassed.

Decomposition:
- core_pkg additions: fetch_pair_t {pc, instr0, instr1}; IMEM_LATENCY=1; FETCH_PAIR_BYTES=8.
- One sub-module: fetch_pair_fifo (synchronous FIFO of fetch_pair_t, parameter DEPTH) with push, pop, flush (flush wins), head, count, full, empty.
- The epoch, credit and issue logic stays in imem_fetch_ctrl.

Test Plan:
Memory image for all scenarios: imem[k] = 32'h11111111*(k+1) for k=0..11.
1. Reset release, fetch_en=1 from cycle 1 -> imem_ren in cycle 1 with addr0=0x0, addr1=0x4; if_valid=2'b11 in cycle 3 with PCs 0x0/0x4, instrs 0x11111111/0x22222222; then 0x8/0xC in cycle 4, one pair per cycle.
2. stall=1 for 5 cycles during streaming -> outputs frozen; imem_ren drops once occupancy+inflight=4; after release, pairs 0x10, 0x18, 0x20 arrive in order with no loss or duplication.
3. redirect_en for one cycle with redirect_pc=0x0000_000A -> if_valid=0 for two cycles; first output pair has PCs 0x8/0xC with 0x33333333/0x44444444; the stale pair issued before the redirect never appears.
4. pc forced near the top (redirect_pc=0xFFFF_FFF8), fetch two pairs -> second request addr0=0x0000_0000; no X on outputs.
5. Force imem_valid=1 with no request outstanding -> proto_err=1 and stays set; queue unchanged.
6. Assert reset low mid-stream while occupancy=3 and a request is in flight -> outputs cleared immediately; after release, fetch restarts at RESET_PC with no stale entries.
